shift_seq_ctrl: RTL and testbench

- Sequencer for the team's 8-bit parallel-load shift register.
- Accepts a parallel word over a valid/ready handshake, loads it, then drives it out serially one bit per clock in a chosen direction.
- Reports completion with a one-cycle done pulse.
- Sits between a word-level producer (CPU or test logic) and a single-wire serial consumer.

---
 rtl/shift_seq_pkg.sv | 16 +
 rtl/shift_seq_datapath.sv | 43 ++++
 rtl/shift_seq_ctrl.sv | 118 +++++++++++
 tb/tb_shift_seq_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift-register sequencer.
//   state_t       : controller state encoding (IDLE, SHIFT, DONE)
//   DIR_MSB_FIRST : serialize starting at bit WIDTH-1
//   DIR_LSB_FIRST : serialize starting at bit 0
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_seq_datapath.sv
// WIDTH-bit parallel-load shift register with a serial-out mux.
// The direction is latched together with the word so that later changes
// on the producer side cannot disturb a word that is being sent.
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   load       : capture data_in and dir_in
//   shift      : move the register one place toward the output end, zero fill
//   dir_in     : direction to latch on load (DIR_MSB_FIRST / DIR_LSB_FIRST)
//   data_in    : parallel word
//   ser_bit    : bit currently at the output end of the register
module shift_seq_datapath
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic             dir_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             ser_bit
);

  logic [WIDTH-1:0] data_q;
  logic             dir_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      dir_q  <= DIR_MSB_FIRST;
    end else if (load) begin
      data_q <= data_in;
      dir_q  <= dir_in;
    end else if (shift) begin
      if (dir_q == DIR_LSB_FIRST) data_q <= {1'b0, data_q[WIDTH-1:1]};
      else                        data_q <= {data_q[WIDTH-2:0], 1'b0};
    end
  end

  assign ser_bit = (dir_q == DIR_LSB_FIRST) ? data_q[0] : data_q[WIDTH-1];

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer for the parallel-load shift register: accepts a word over a
// valid/ready handshake, shifts it out one bit per clock and pulses done.
// Optional build macro: SHIFT_SEQ_CTRL_PARITY_EN appends an even-parity beat
// after the data bits.
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   s_valid    : producer has a word on s_data
//   s_ready    : controller can accept a word this cycle
//   s_data     : parallel word to serialize
//   s_dir      : 0 = MSB first, 1 = LSB first (sampled at accept)
//   ser_out    : serial data bit
//   ser_valid  : ser_out carries a valid bit
//   busy       : high in SHIFT and DONE
//   done       : one-cycle pulse after the last bit
//
// state | meaning
// IDLE  | waiting for a word, s_ready high
// SHIFT | driving one bit per clock, counter holds beats remaining
// DONE  | single-cycle done pulse, then back to IDLE
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_dir,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 2);
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(WIDTH + 1);
`else
  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(WIDTH);
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load, shift, ser_bit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s_valid) begin
          load    = 1'b1;
          cnt_d   = LOAD_CNT;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  shift_seq_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .shift   (shift),
    .dir_in  (s_dir),
    .data_in (s_data),
    .ser_bit (ser_bit)
  );

`ifdef SHIFT_SEQ_CTRL_PARITY_EN
  // Parity is captured at accept because the register is zero-filled by the
  // time the parity beat is sent.
  logic par_q;

  always_ff @(posedge clk) begin
    if (reset)     par_q <= 1'b0;
    else if (load) par_q <= ^s_data;
  end

  // The last beat (counter == 1) carries parity instead of register data.
  assign ser_out = (state_q == SHIFT) &
                   ((cnt_q == CNT_W'(1)) ? par_q : ser_bit);
`else
  assign ser_out = (state_q == SHIFT) & ser_bit;
`endif

  assign s_ready   = (state_q == IDLE);
  assign ser_valid = (state_q == SHIFT);
  assign busy      = (state_q == SHIFT) | (state_q == DONE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
module tb_shift_seq_ctrl;

  localparam int WIDTH = 8;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int PERIOD = WIDTH + 2 + PAR;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [WIDTH-1:0] s_data = '0;
  logic             s_dir = 1'b0;
  logic             ser_out, ser_valid, busy, done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;
  bit chk_en  = 1'b0;

  shift_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_dir     (s_dir),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Reference model: a schedule of expected output tuples per cycle,
  // {s_ready, busy, done, ser_valid, ser_out}. Empty schedule means idle.
  localparam logic [4:0] IDLE_T = 5'b10000;
  logic [4:0] sched[$];

  always @(posedge clk) begin
    cyc_n++;
    if (reset) begin
      sched.delete();
    end else if (sched.size() > 0) begin
      void'(sched.pop_front());
    end else if (s_valid) begin
      logic par;
      par = ^s_data;
      for (int i = 0; i < WIDTH; i++)
        sched.push_back({4'b0101, s_dir ? s_data[i] : s_data[WIDTH-1-i]});
      if (PAR != 0) sched.push_back({4'b0101, par});
      sched.push_back(5'b01100);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [4:0] exp;
      exp = (sched.size() > 0) ? sched[0] : IDLE_T;
      chk("model", {s_ready, busy, done, ser_valid, ser_out}, exp);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one word and checks the bit sequence against literal expectations.
  // exp8 lists the data beats with the first beat at bit 7.
  task automatic directed(input string name, input logic [7:0] d, input logic dir,
                          input logic [7:0] exp8, input logic par_lit, input bit toggle);
    s_valid = 1'b1;
    s_data  = d;
    s_dir   = dir;
    step();
    if (toggle) begin
      s_data = 8'hFF;
      s_dir  = ~dir;
    end else begin
      s_valid = 1'b0;
    end
    for (int k = 0; k < WIDTH + PAR; k++) begin
      chk({name, "_valid"}, ser_valid, 1'b1);
      if (k < WIDTH) chk({name, "_bit"}, ser_out, exp8[7-k]);
      else           chk({name, "_par"}, ser_out, par_lit);
      if (toggle) chk({name, "_ready_lo"}, s_ready, 1'b0);
      step();
    end
    chk({name, "_done"}, done, 1'b1);
    s_valid = 1'b0;
    step();
    chk({name, "_ready"}, s_ready, 1'b1);
    chk({name, "_done_lo"}, done, 1'b0);
  endtask

  initial begin
    int acc1, acc2, done_cnt;

    reset = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_ready", s_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", ser_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_out", ser_out, 1'b0);
    step();

    directed("a5", 8'hA5, 1'b0, 8'b10100101, 1'b0, 1'b0);
    directed("x01", 8'h01, 1'b1, 8'b10000000, 1'b1, 1'b1);

    // Back-to-back words with s_valid held high.
    acc1 = -1;
    acc2 = -1;
    s_valid = 1'b1;
    s_data  = 8'h3C;
    s_dir   = 1'b0;
    for (int t = 0; t < 4 * PERIOD && acc2 < 0; t++) begin
      if (s_ready && s_valid) begin
        if (acc1 < 0) acc1 = cyc_n;
        else          acc2 = cyc_n;
      end
      step();
      if (acc1 >= 0) s_data = 8'hC3;
    end
    s_valid = 1'b0;
    chk("b2b_spacing", acc2 - acc1, PERIOD);
    for (int t = 0; t < PERIOD + 2; t++) step();

    // Reset after the third bit of F0.
    s_valid = 1'b1;
    s_data  = 8'hF0;
    s_dir   = 1'b0;
    step();
    s_valid = 1'b0;
    step();
    step();
    step();
    chk("abort_pre_busy", busy, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_valid", ser_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    done_cnt = 0;
    for (int t = 0; t < PERIOD; t++) begin
      if (done) done_cnt++;
      step();
    end
    chk("abort_no_done", done_cnt, 0);
    directed("x0f", 8'h0F, 1'b0, 8'b00001111, 1'b0, 1'b0);

`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    directed("par07", 8'h07, 1'b0, 8'b00000111, 1'b1, 1'b0);
`endif

    // Random traffic, occasional resets, checked against the model.
    for (int t = 0; t < 3000; t++) begin
      s_valid = ($urandom_range(0, 2) != 0);
      s_data  = WIDTH'($urandom);
      s_dir   = 1'($urandom);
      reset   = ($urandom_range(0, 99) == 0);
      step();
    end
    reset   = 1'b0;
    s_valid = 1'b0;
    for (int t = 0; t < PERIOD + 2; t++) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
